// File: rtl/magic_packet_driver_if.sv
// Purpose: request/stimulus bundle between a free stimulus source and the
//          magic-packet driver.
// Signals:
//   push_req, pop_req, start_req, data_req : unconstrained requests (source -> driver)
//   push, pop, start, data_in              : legal FIFO stimulus (driver -> FIFO DUT)
// Modports:
//   master : the request source (testbench / formal environment)
//   slave  : the driver itself
interface magic_packet_driver_if #(
   parameter int WIDTH = 8
);
   logic             push_req;
   logic             pop_req;
   logic             start_req;
   logic [WIDTH-1:0] data_req;
   logic             push;
   logic             pop;
   logic             start;
   logic [WIDTH-1:0] data_in;

   modport master (
      output push_req, pop_req, start_req, data_req,
      input  push, pop, start, data_in
   );

   modport slave (
      input  push_req, pop_req, start_req, data_req,
      output push, pop, start, data_in
   );
endinterface

// File: rtl/magic_packet_driver.sv
// Purpose: turns free push/pop/start requests into legal stimulus for a
//          DEPTH-entry FIFO, follows the magic packet through the queue and
//          flags the cycle in which it must leave the FIFO.
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   bus (slave)     : requests in, legal push/pop/start/data_in out
//   cnt_o           : registered FIFO occupancy (0..DEPTH)
//   full_o, empty_o : occupancy flags
//   state_o         : 00 IDLE, 01 TRACK, 10 DONE
//   magic_data_o    : captured value of the magic packet
//   magic_popped_o  : magic packet is popped this cycle
//
// state | meaning
// IDLE  | no magic packet issued yet; start allowed with a legal push
// TRACK | magic packet inside FIFO; ahead_q counts entries still in front
// DONE  | magic packet has left; sticky until reset
module magic_packet_driver #(
   parameter int DEPTH  = 8,
   parameter int WIDTH  = 8,
   parameter int CNTWID = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   magic_packet_driver_if.slave  bus,
   output logic [CNTWID-1:0]     cnt_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [1:0]            state_o,
   output logic [WIDTH-1:0]      magic_data_o,
   output logic                  magic_popped_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_TRACK = 2'b01,
      S_DONE  = 2'b10
   } state_t;

   state_t            state_q;
   logic [CNTWID-1:0] cnt_q;
   logic [CNTWID-1:0] cnt_d;
   logic [CNTWID-1:0] ahead_q;
   logic [WIDTH-1:0]  magic_data_q;
   logic              full_w;
   logic              empty_w;
   logic              push_w;
   logic              pop_w;
   logic              start_w;
   logic              magic_popped_w;

   assign full_w  = (cnt_q == CNTWID'(DEPTH));
   assign empty_w = (cnt_q == '0);

   // Reset forces cnt to 0 (empty) but not full, so push needs its own gate
   // to stay low while rst is held.
   assign push_w  = bus.push_req & ~full_w & ~rst;
   assign pop_w   = bus.pop_req & ~empty_w;
   assign start_w = bus.start_req & push_w & (state_q == S_IDLE);

   // The magic entry cannot pop in its capture cycle: state is still IDLE then.
   assign magic_popped_w = (state_q == S_TRACK) & pop_w & (ahead_q == '0);

   assign cnt_d = cnt_q + CNTWID'(push_w) - CNTWID'(pop_w);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         ahead_q      <= '0;
         magic_data_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         case (state_q)
            S_IDLE: begin
               if (start_w) begin
                  state_q      <= S_TRACK;
                  magic_data_q <= bus.data_req;
                  // A pop in the capture cycle removes one entry ahead of the magic one.
                  ahead_q      <= cnt_q - CNTWID'(pop_w);
               end
            end
            S_TRACK: begin
               if (pop_w) begin
                  if (ahead_q == '0) begin
                     state_q <= S_DONE;
                  end else begin
                     ahead_q <= ahead_q - 1'b1;
                  end
               end
            end
            default: state_q <= S_DONE;
         endcase
      end
   end

   assign bus.push       = push_w;
   assign bus.pop        = pop_w;
   assign bus.start      = start_w;
   assign bus.data_in    = bus.data_req;
   assign cnt_o          = cnt_q;
   assign full_o         = full_w;
   assign empty_o        = empty_w;
   assign state_o        = state_q;
   assign magic_data_o   = magic_data_q;
   assign magic_popped_o = magic_popped_w;

endmodule

// File: tb/tb_magic_packet_driver.sv
module tb_magic_packet_driver;

   localparam int DEPTH = 8;

   typedef struct packed {
      logic       push;
      logic       pop;
      logic       start;
      logic [7:0] data_in;
      logic       magic_popped;
      logic       full;
      logic       empty;
      logic [3:0] cnt;
      logic [1:0] state;
      logic [7:0] magic_data;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] cnt_o;
   logic       full_o;
   logic       empty_o;
   logic [1:0] state_o;
   logic [7:0] magic_data_o;
   logic       magic_popped_o;

   int vec_cnt     = 0;
   int miscompares = 0;

   obs_t exp_q[$];

   // reference model state
   logic [3:0] m_cnt;
   logic [1:0] m_state;
   logic [3:0] m_ahead;
   logic [7:0] m_magic;

   magic_packet_driver_if #(.WIDTH(8)) bus ();

   magic_packet_driver #(.DEPTH(DEPTH), .WIDTH(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .cnt_o          (cnt_o),
      .full_o         (full_o),
      .empty_o        (empty_o),
      .state_o        (state_o),
      .magic_data_o   (magic_data_o),
      .magic_popped_o (magic_popped_o)
   );

   always #5 clk = ~clk;

   function automatic obs_t observe();
      obs_t o;
      o.push         = bus.push;
      o.pop          = bus.pop;
      o.start        = bus.start;
      o.data_in      = bus.data_in;
      o.magic_popped = magic_popped_o;
      o.full         = full_o;
      o.empty        = empty_o;
      o.cnt          = cnt_o;
      o.state        = state_o;
      o.magic_data   = magic_data_o;
      return o;
   endfunction

   task automatic model_reset();
      m_cnt   = '0;
      m_state = 2'b00;
      m_ahead = '0;
      m_magic = '0;
      exp_q.delete();
   endtask

   // Called just after a falling edge: drives requests, queues the expected
   // pre-edge outputs, advances the model across the coming rising edge.
   task automatic step(input logic pr, input logic po, input logic sr, input logic [7:0] d);
      obs_t e;
      bus.push_req  = pr;
      bus.pop_req   = po;
      bus.start_req = sr;
      bus.data_req  = d;
      e.full         = (m_cnt == 4'(DEPTH));
      e.empty        = (m_cnt == 4'd0);
      e.push         = pr & ~e.full;
      e.pop          = po & ~e.empty;
      e.start        = sr & e.push & (m_state == 2'b00);
      e.data_in      = d;
      e.magic_popped = (m_state == 2'b01) & e.pop & (m_ahead == 4'd0);
      e.cnt          = m_cnt;
      e.state        = m_state;
      e.magic_data   = m_magic;
      exp_q.push_back(e);
      if (e.start) begin
         m_state = 2'b01;
         m_magic = d;
         m_ahead = m_cnt - 4'(e.pop);
      end else if (m_state == 2'b01 && e.pop) begin
         if (m_ahead == 4'd0) m_state = 2'b10;
         else                 m_ahead = m_ahead - 4'd1;
      end
      m_cnt = m_cnt + 4'(e.push) - 4'(e.pop);
      #1;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.push_req  = 1'b0;
      bus.pop_req   = 1'b0;
      bus.start_req = 1'b0;
      bus.data_req  = 8'h00;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      obs_t o;
      obs_t e;
      bus.push_req  = 1'b1;
      bus.pop_req   = 1'b1;
      bus.start_req = 1'b1;
      bus.data_req  = 8'h5A;
      #1;
      e = '{push:1'b0, pop:1'b0, start:1'b0, data_in:8'h5A, magic_popped:1'b0,
            full:1'b0, empty:1'b1, cnt:4'd0, state:2'b00, magic_data:8'h00};
      o = observe();
      vec_cnt++;
      if (o !== e) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h want %h", o, e);
      end
      do_reset();
   endtask

   task automatic test_push_basic();
      obs_t o;
      obs_t e;
      logic [7:0] vals [3];
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, vals[i]);
         o = observe(); e = exp_q.pop_front(); vec_cnt++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL push_basic cyc %0d: got %h want %h", i, o, e);
         end
         @(negedge clk);
      end
      vec_cnt++;
      if (cnt_o !== 4'd3 || empty_o !== 1'b0) begin
         miscompares++;
         $display("FAIL push_basic_cnt: got cnt %0d empty %b want cnt 3 empty 0", cnt_o, empty_o);
      end
   endtask

   task automatic test_fill();
      obs_t o;
      obs_t e;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         step(1'b1, 1'b0, 1'b0, 8'(i + 1));
         o = observe(); e = exp_q.pop_front(); vec_cnt++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL fill cyc %0d: got %h want %h", i, o, e);
         end
         vec_cnt++;
         if (bus.push !== (i < 8)) begin
            miscompares++;
            $display("FAIL fill_push cyc %0d: got %b want %b", i, bus.push, (i < 8));
         end
         @(negedge clk);
      end
      vec_cnt++;
      if (cnt_o !== 4'd8 || full_o !== 1'b1) begin
         miscompares++;
         $display("FAIL fill_full: got cnt %0d full %b want cnt 8 full 1", cnt_o, full_o);
      end
      // full with both requests: pop only
      step(1'b1, 1'b1, 1'b0, 8'hEE);
      o = observe(); e = exp_q.pop_front(); vec_cnt++;
      if (o !== e) begin
         miscompares++;
         $display("FAIL full_push_pop: got %h want %h", o, e);
      end
      @(negedge clk);
      vec_cnt++;
      if (cnt_o !== 4'd7) begin
         miscompares++;
         $display("FAIL full_push_pop_cnt: got %0d want 7", cnt_o);
      end
   endtask

   task automatic test_empty_pop();
      obs_t o;
      obs_t e;
      do_reset();
      step(1'b0, 1'b1, 1'b0, 8'h01);
      o = observe(); e = exp_q.pop_front(); vec_cnt++;
      if (o !== e || bus.pop !== 1'b0) begin
         miscompares++;
         $display("FAIL empty_pop: got %h want %h", o, e);
      end
      @(negedge clk);
      step(1'b1, 1'b1, 1'b0, 8'h02);
      o = observe(); e = exp_q.pop_front(); vec_cnt++;
      if (o !== e || bus.push !== 1'b1 || bus.pop !== 1'b0) begin
         miscompares++;
         $display("FAIL empty_push_pop: got %h want %h", o, e);
      end
      @(negedge clk);
      vec_cnt++;
      if (cnt_o !== 4'd1) begin
         miscompares++;
         $display("FAIL empty_push_pop_cnt: got %0d want 1", cnt_o);
      end
   endtask

   task automatic test_magic_track();
      obs_t o;
      obs_t e;
      logic mp_want;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
         o = observe(); e = exp_q.pop_front(); vec_cnt++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL magic_prefill cyc %0d: got %h want %h", i, o, e);
         end
         @(negedge clk);
      end
      step(1'b1, 1'b0, 1'b1, 8'hA5);
      o = observe(); e = exp_q.pop_front(); vec_cnt++;
      if (o !== e || bus.start !== 1'b1) begin
         miscompares++;
         $display("FAIL magic_start: got %h want %h", o, e);
      end
      @(negedge clk);
      vec_cnt++;
      if (state_o !== 2'b01 || magic_data_o !== 8'hA5) begin
         miscompares++;
         $display("FAIL magic_capture: got state %b data %h want state 01 data a5", state_o, magic_data_o);
      end
      for (int i = 0; i < 3; i++) begin
         mp_want = (i == 2);
         step(1'b0, 1'b1, 1'b0, 8'h00);
         o = observe(); e = exp_q.pop_front(); vec_cnt++;
         if (o !== e || magic_popped_o !== mp_want) begin
            miscompares++;
            $display("FAIL magic_pop cyc %0d: got %h want %h", i, o, e);
         end
         @(negedge clk);
      end
      vec_cnt++;
      if (state_o !== 2'b10) begin
         miscompares++;
         $display("FAIL magic_done: got state %b want 10", state_o);
      end
      step(1'b1, 1'b0, 1'b1, 8'h77);
      o = observe(); e = exp_q.pop_front(); vec_cnt++;
      if (o !== e || bus.start !== 1'b0) begin
         miscompares++;
         $display("FAIL magic_no_restart: got %h want %h", o, e);
      end
      @(negedge clk);
   endtask

   task automatic test_start_with_pop();
      obs_t o;
      obs_t e;
      logic mp_want;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
         o = observe(); e = exp_q.pop_front(); vec_cnt++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL sp_prefill cyc %0d: got %h want %h", i, o, e);
         end
         @(negedge clk);
      end
      step(1'b1, 1'b1, 1'b1, 8'h3C);
      o = observe(); e = exp_q.pop_front(); vec_cnt++;
      if (o !== e || bus.start !== 1'b1 || bus.pop !== 1'b1) begin
         miscompares++;
         $display("FAIL sp_start_pop: got %h want %h", o, e);
      end
      @(negedge clk);
      vec_cnt++;
      if (cnt_o !== 4'd3) begin
         miscompares++;
         $display("FAIL sp_cnt: got %0d want 3", cnt_o);
      end
      // two entries ahead: magic leaves on the third pop
      for (int i = 0; i < 3; i++) begin
         mp_want = (i == 2);
         step(1'b0, 1'b1, 1'b0, 8'h00);
         o = observe(); e = exp_q.pop_front(); vec_cnt++;
         if (o !== e || magic_popped_o !== mp_want) begin
            miscompares++;
            $display("FAIL sp_pop cyc %0d: got %h want %h", i, o, e);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_async_reset();
      obs_t o;
      obs_t e;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, (i == 3), 8'(8'hC0 + i));
         o = observe(); e = exp_q.pop_front(); vec_cnt++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL ar_setup cyc %0d: got %h want %h", i, o, e);
         end
         @(negedge clk);
      end
      vec_cnt++;
      if (state_o !== 2'b01 || cnt_o !== 4'd4) begin
         miscompares++;
         $display("FAIL ar_track: got state %b cnt %0d want state 01 cnt 4", state_o, cnt_o);
      end
      bus.push_req = 1'b1;
      bus.pop_req  = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      vec_cnt++;
      if (state_o !== 2'b00 || cnt_o !== 4'd0 || bus.push !== 1'b0 || bus.pop !== 1'b0 ||
          magic_popped_o !== 1'b0 || empty_o !== 1'b1) begin
         miscompares++;
         $display("FAIL async_reset: got state %b cnt %0d push %b pop %b mp %b want 00 0 0 0 0",
                  state_o, cnt_o, bus.push, bus.pop, magic_popped_o);
      end
      @(negedge clk);
      do_reset();
   endtask

   task automatic test_random();
      obs_t o;
      obs_t e;
      for (int ep = 0; ep < 3; ep++) begin
         do_reset();
         for (int i = 0; i < 150; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 7) == 0), 8'($urandom));
            o = observe(); e = exp_q.pop_front(); vec_cnt++;
            if (o !== e) begin
               miscompares++;
               $display("FAIL random ep %0d cyc %0d: got %h want %h", ep, i, o, e);
            end
            @(negedge clk);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_push_basic();
      test_fill();
      test_empty_pop();
      test_magic_track();
      test_start_with_pop();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
      $finish;
   end

endmodule
